// File: rtl/regs_wb_queue.sv
// Write-back queue for the 8x16 dual-write register file: buffers execute-stage
// writes and drains up to two per cycle, in program order, onto a shared-enable port pair.
module regs_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     flush,
    output logic                     wen,
    output logic [AW-1:0]            waddr0,
    output logic [DW-1:0]            wdata0,
    output logic [AW-1:0]            waddr1,
    output logic [DW-1:0]            wdata1,
    input  logic [AW-1:0]            chk_addr,
    output logic                     chk_busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr1;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          illegal;
    logic          enq;
    logic [1:0]    pop_n;
    logic [PW-1:0] off;

    assign count    = count_q;
    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = in_valid & in_ready & ~flush;
    assign illegal  = in_addr[AW-1];
    assign enq      = push & ~illegal;
    assign rd_ptr1  = rd_ptr + PW'(1);

    // Pop decision looks only at the occupancy before this edge's push.
    always_comb begin
        if (count_q >= CW'(2)) begin
            pop_n = 2'd2;
        end else if (count_q == CW'(1)) begin
            pop_n = 2'd1;
        end else begin
            pop_n = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            wen     <= 1'b0;
            waddr0  <= '0;
            wdata0  <= '0;
            waddr1  <= '0;
            wdata1  <= '0;
            err     <= 1'b0;
        end else begin
            if (push && illegal) begin
                err <= 1'b1;
            end
            if (flush) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count_q <= '0;
                wen     <= 1'b0;
            end else begin
                if (enq) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                // A single pending write is mirrored on both ports since the enable is shared.
                case (pop_n)
                    2'd2: begin
                        rd_ptr <= rd_ptr + PW'(2);
                        waddr0 <= addr_mem[rd_ptr];
                        wdata0 <= data_mem[rd_ptr];
                        waddr1 <= addr_mem[rd_ptr1];
                        wdata1 <= data_mem[rd_ptr1];
                        wen    <= 1'b1;
                    end
                    2'd1: begin
                        rd_ptr <= rd_ptr1;
                        waddr0 <= addr_mem[rd_ptr];
                        wdata0 <= data_mem[rd_ptr];
                        waddr1 <= addr_mem[rd_ptr];
                        wdata1 <= data_mem[rd_ptr];
                        wen    <= 1'b1;
                    end
                    default: begin
                        wen <= 1'b0;
                    end
                endcase
                count_q <= count_q + CW'(enq) - CW'(pop_n);
            end
        end
    end

    always_comb begin
        chk_busy = 1'b0;
        off      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = PW'(i) - rd_ptr;
            if (({1'b0, off} < count_q) && (addr_mem[i] == chk_addr)) begin
                chk_busy = 1'b1;
            end
        end
        if (wen && ((waddr0 == chk_addr) || (waddr1 == chk_addr))) begin
            chk_busy = 1'b1;
        end
        if (in_valid && in_ready && (in_addr == chk_addr)) begin
            chk_busy = 1'b1;
        end
    end

endmodule

// File: tb/tb_regs_wb_queue.sv
// Scoreboard bench for regs_wb_queue: expected writes queued at drive time and
// matched against the write port, with a small register-file model fed by the ports.
module tb_regs_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int DW    = 16;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          wen;
    logic [AW-1:0] waddr0;
    logic [DW-1:0] wdata0;
    logic [AW-1:0] waddr1;
    logic [DW-1:0] wdata1;
    logic [AW-1:0] chk_addr;
    logic          chk_busy;
    logic [2:0]    count;
    logic          err;

    regs_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .flush(flush), .wen(wen),
        .waddr0(waddr0), .wdata0(wdata0), .waddr1(waddr1), .wdata1(wdata1),
        .chk_addr(chk_addr), .chk_busy(chk_busy), .count(count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           sb[$];
    int            total = 0;
    int            bad = 0;
    int            mcount = 0;
    int            exp_pops = 0;
    logic [DW-1:0] rf [8];

    // Occupancy model and register-file consumer, evaluated at each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mcount   = 0;
            exp_pops = 0;
            sb.delete();
        end else begin
            if (wen === 1'b1) begin
                rf[waddr0[2:0]] = wdata0;
                rf[waddr1[2:0]] = wdata1;
            end
            if (flush) begin
                mcount   = 0;
                exp_pops = 0;
                sb.delete();
            end else begin
                int acc;
                acc = (in_valid && (mcount < DEPTH) && !in_addr[AW-1]) ? 1 : 0;
                exp_pops = (mcount >= 2) ? 2 : mcount;
                mcount = mcount - exp_pops + acc;
            end
        end
    end

    // Write-port monitor: pops the scoreboard whenever the DUT presents writes.
    always @(negedge clk) begin
        if (!reset) begin
            wr_t e0;
            wr_t e1;
            total++;
            if (wen !== (exp_pops != 0)) begin
                bad++;
                $display("FAIL wen got=%b exp=%b", wen, (exp_pops != 0));
            end
            if (exp_pops > 0 && wen === 1'b1) begin
                total++;
                if (sb.size() < exp_pops) begin
                    bad++;
                    $display("FAIL sb_underflow got=%0d exp>=%0d", sb.size(), exp_pops);
                end else begin
                    e0 = sb.pop_front();
                    e1 = (exp_pops == 2) ? sb.pop_front() : e0;
                    if ({waddr0, wdata0, waddr1, wdata1} !== {e0, e1}) begin
                        bad++;
                        $display("FAIL order got=%h/%h,%h/%h exp=%h/%h,%h/%h",
                                 waddr0, wdata0, waddr1, wdata1, e0.a, e0.d, e1.a, e1.d);
                    end
                end
            end
            total++;
            if (count !== 3'(mcount)) begin
                bad++;
                $display("FAIL count got=%0d exp=%0d", count, mcount);
            end
        end
    end

    task automatic push_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        if (!a[AW-1] && mcount < DEPTH) sb.push_back({a, d});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        total++;
        if ({wen, count, err, waddr0, wdata0, waddr1, wdata1} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b,%0d,%b,%h,%h,%h,%h exp=0",
                     wen, count, err, waddr0, wdata0, waddr1, wdata1);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_single;
        push_req(4'd3, 16'hA5A5);
        in_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({wen, waddr0, waddr1, wdata0, wdata1} !== {1'b1, 4'd3, 4'd3, 16'hA5A5, 16'hA5A5}) begin
            bad++;
            $display("FAIL single_port got=%b %h %h %h %h exp=1 3 3 a5a5 a5a5",
                     wen, waddr0, waddr1, wdata0, wdata1);
        end
        @(posedge clk); #1;
        total++;
        if (wen !== 1'b0 || rf[3] !== 16'hA5A5) begin
            bad++;
            $display("FAIL single_done got=wen%b rf%h exp=wen0 rfa5a5", wen, rf[3]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        push_req(4'd1, 16'h0011);
        push_req(4'd2, 16'h0022);
        push_req(4'd5, 16'h0055);
        idle(4);
        total++;
        if ({rf[1], rf[2], rf[5]} !== {16'h0011, 16'h0022, 16'h0055}) begin
            bad++;
            $display("FAIL b2b_rf got=%h %h %h exp=0011 0022 0055", rf[1], rf[2], rf[5]);
        end
    endtask

    task automatic test_burst_wrap;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (in_ready !== (mcount < DEPTH)) begin
                bad++;
                $display("FAIL burst_ready got=%b exp=%b", in_ready, (mcount < DEPTH));
            end
            push_req(4'(i % 8), 16'hB000 + 16'(i));
        end
        idle(4);
        total++;
        if ({rf[0], rf[1], rf[7]} !== {16'hB008, 16'hB009, 16'hB007}) begin
            bad++;
            $display("FAIL burst_rf got=%h %h %h exp=b008 b009 b007", rf[0], rf[1], rf[7]);
        end
    endtask

    task automatic test_same_addr;
        push_req(4'd4, 16'h1111);
        push_req(4'd4, 16'h2222);
        idle(4);
        total++;
        if (rf[4] !== 16'h2222) begin
            bad++;
            $display("FAIL same_addr_rf got=%h exp=2222", rf[4]);
        end
    endtask

    task automatic test_hazard_flush;
        chk_addr = 4'd6;
        push_req(4'd6, 16'h0666);
        in_valid = 1'b1;
        in_addr  = 4'd7;
        in_data  = 16'h0777;
        sb.push_back({4'd7, 16'h0777});
        #1;
        total++;
        if (chk_busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_queued got=%b exp=1", chk_busy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        total++;
        if (chk_busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_staged got=%b exp=1", chk_busy);
        end
        chk_addr = 4'd7;
        #1;
        total++;
        if (chk_busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_fifo7 got=%b exp=1", chk_busy);
        end
        @(negedge clk);
        flush    = 1'b0;
        chk_addr = 4'd6;
        #1;
        total++;
        if ({count, wen, chk_busy} !== {3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL flush_state got=count%0d wen%b busy%b exp=0 0 0", count, wen, chk_busy);
        end
        chk_addr = 4'd7;
        #1;
        total++;
        if (chk_busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_busy7 got=%b exp=0", chk_busy);
        end
        total++;
        if (rf[6] !== 16'h0666 || rf[7] !== 16'hB007) begin
            bad++;
            $display("FAIL flush_rf got=%h %h exp=0666 b007", rf[6], rf[7]);
        end
        // Illegal address: accepted, never written, latches err.
        chk_addr = 4'h9;
        in_valid = 1'b1;
        in_addr  = 4'h9;
        in_data  = 16'hDEAD;
        #1;
        total++;
        if (chk_busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_input got=%b exp=1", chk_busy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (err !== 1'b1 || count !== 3'd0) begin
            bad++;
            $display("FAIL illegal got=err%b count%0d exp=err1 count0", err, count);
        end
        idle(3);
        total++;
        if (err !== 1'b1 || wen !== 1'b0) begin
            bad++;
            $display("FAIL err_sticky got=err%b wen%b exp=err1 wen0", err, wen);
        end
    endtask

    task automatic test_reset_mid;
        push_req(4'd1, 16'h0101);
        push_req(4'd2, 16'h0202);
        in_valid = 1'b1;
        in_addr  = 4'd3;
        in_data  = 16'h0303;
        sb.push_back({4'd3, 16'h0303});
        @(posedge clk); #1;
        total++;
        if (wen !== 1'b1 || count !== 3'd1) begin
            bad++;
            $display("FAIL pre_reset got=wen%b count%0d exp=wen1 count1", wen, count);
        end
        #1 reset = 1'b1;
        in_valid = 1'b0;
        #1;
        total++;
        if ({wen, count, err, waddr0, wdata0, waddr1, wdata1} !== '0) begin
            bad++;
            $display("FAIL async_reset got=%b,%0d,%b,%h,%h,%h,%h exp=0",
                     wen, count, err, waddr0, wdata0, waddr1, wdata1);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || rf[3] === 16'h0303) begin
            bad++;
            $display("FAIL post_reset got=ready%b rf3=%h exp=ready1 rf3!=0303", in_ready, rf[3]);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        flush    = 1'b0;
        chk_addr = '0;
        for (int i = 0; i < 8; i++) rf[i] = '0;
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_burst_wrap();
        test_same_addr();
        test_hazard_flush();
        test_reset_mid();
        begin
            int waited;
            waited = 0;
            while ((sb.size() != 0 || mcount != 0) && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            total++;
            if (sb.size() != 0 || mcount != 0) begin
                bad++;
                $display("FAIL drain_timeout got=%0d pending exp=0", sb.size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
